// File: rtl/inst_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage: opcodes, format classes
// and the width of one buffered decode entry.
package inst_decode_stage_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcSys    = 7'b1110011;

  localparam logic [2:0] F3Sll = 3'b001;
  localparam logic [2:0] F3Sr  = 3'b101;

  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  typedef enum logic [3:0] {
    FmtR     = 4'd0,
    FmtI     = 4'd1,
    FmtL     = 4'd2,
    FmtS     = 4'd3,
    FmtB     = 4'd4,
    FmtLui   = 4'd5,
    FmtAuipc = 4'd6,
    FmtJal   = 4'd7,
    FmtJalr  = 4'd8,
    FmtSys   = 4'd9,
    FmtFence = 4'd10,
    FmtBad   = 4'd11
  } fmt_e;

  // opcode + funct3 + funct7 + rs1/rs2/rd + fmt + illegal
  localparam int unsigned EntryFixedBits = 7 + 3 + 7 + 15 + 4 + 1;

  // Entry carries pc and imm, each XLEN wide, plus the fixed fields.
  function automatic int unsigned entry_width(int unsigned xlen);
    return 2 * xlen + EntryFixedBits;
  endfunction

endpackage

// File: rtl/inst_imm_gen.sv
// Combinational immediate generator, format classifier and illegal-instruction
// detector for RV32I/RV64I base encodings.
module inst_imm_gen
  import inst_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          MEXT = 1'b0
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_shift;
  logic            shift_ok;
  logic            r_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr, imm_sh;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i   = XLEN'($signed(inst[31:20]));
  assign imm_s   = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b   = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_csr = XLEN'(inst[31:20]);
  assign imm_sh  = (XLEN == 32) ? XLEN'(inst[24:20]) : XLEN'(inst[25:20]);

  assign is_shift = (funct3 == F3Sll) || (funct3 == F3Sr);

  // On RV64 inst[25] is the top shamt bit, so only the upper six bits are checked.
  assign shift_ok = (XLEN == 32) ?
      ((funct7 == F7Zero) || ((funct3 == F3Sr) && (funct7 == F7Alt))) :
      ((inst[31:26] == 6'b000000) || ((funct3 == F3Sr) && (inst[31:26] == 6'b010000)));

  assign r_ok = (funct7 == F7Zero) || (funct7 == F7Alt) || (MEXT && (funct7 == F7Mul));

  always_comb begin
    imm     = '0;
    fmt     = FmtBad;
    illegal = 1'b1;
    if (inst[1:0] == 2'b11) begin
      case (opcode)
        OpcOp: begin
          fmt     = FmtR;
          illegal = !r_ok;
        end
        OpcOpImm: begin
          fmt     = FmtI;
          illegal = is_shift && !shift_ok;
          imm     = is_shift ? imm_sh : imm_i;
        end
        OpcLoad: begin
          fmt     = FmtL;
          illegal = 1'b0;
          imm     = imm_i;
        end
        OpcJalr: begin
          fmt     = FmtJalr;
          illegal = 1'b0;
          imm     = imm_i;
        end
        OpcStore: begin
          fmt     = FmtS;
          illegal = 1'b0;
          imm     = imm_s;
        end
        OpcBranch: begin
          fmt     = FmtB;
          illegal = 1'b0;
          imm     = imm_b;
        end
        OpcLui: begin
          fmt     = FmtLui;
          illegal = 1'b0;
          imm     = imm_u;
        end
        OpcAuipc: begin
          fmt     = FmtAuipc;
          illegal = 1'b0;
          imm     = imm_u;
        end
        OpcJal: begin
          fmt     = FmtJal;
          illegal = 1'b0;
          imm     = imm_j;
        end
        OpcSys: begin
          fmt     = FmtSys;
          illegal = 1'b0;
          imm     = imm_csr;
        end
        OpcFence: begin
          fmt     = FmtFence;
          illegal = 1'b0;
        end
        default: ;
      endcase
    end
    if (illegal) begin
      fmt = FmtBad;
      imm = '0;
    end
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered instruction-decode stage with valid/ready handshakes and a
// two-entry skid buffer (main M presented downstream, skid K absorbs a stall).
module inst_decode_stage
  import inst_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          MEXT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_fmt,
  output logic            out_illegal
);

  localparam int unsigned EntryW = entry_width(XLEN);

  logic [XLEN-1:0]   dec_imm;
  fmt_e              dec_fmt;
  logic              dec_illegal;
  logic [EntryW-1:0] dec_entry;

  logic [EntryW-1:0] m_q, m_d, k_q, k_d;
  logic              m_valid_q, m_valid_d, k_valid_q, k_valid_d;
  logic              accept, m_free;

  inst_imm_gen #(
    .XLEN (XLEN),
    .MEXT (MEXT)
  ) u_imm_gen (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_entry = {in_pc, in_inst[6:0], in_inst[14:12], in_inst[31:25], in_inst[19:15],
                      in_inst[24:20], in_inst[11:7], dec_imm, dec_fmt, dec_illegal};

  assign in_ready = !k_valid_q;
  assign accept   = in_valid && in_ready;
  // M can take a new entry when empty or being consumed this cycle.
  assign m_free   = !m_valid_q || out_ready;

  always_comb begin
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (m_free) begin
      if (k_valid_q) begin
        m_d       = k_q;
        m_valid_d = 1'b1;
        k_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = dec_entry;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      k_d       = dec_entry;
      k_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
    end
  end

  assign out_valid = m_valid_q;
  assign {out_pc, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
          out_imm, out_fmt, out_illegal} = m_q;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed self-checking bench for inst_decode_stage (RV32 base and RV64+M builds).
module tb_inst_decode_stage;
  import inst_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          failures = 0;

  logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_fmt;

  logic        d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_illegal;
  logic [31:0] d_in_inst;
  logic [63:0] d_in_pc, d_out_pc, d_out_imm;
  logic [6:0]  d_out_opcode, d_out_funct7;
  logic [2:0]  d_out_funct3;
  logic [4:0]  d_out_rs1, d_out_rs2, d_out_rd;
  logic [3:0]  d_out_fmt;

  always #5 clk = ~clk;

  inst_decode_stage #(.XLEN(32), .MEXT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  inst_decode_stage #(.XLEN(64), .MEXT(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(d_flush), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .in_inst(d_in_inst), .in_pc(d_in_pc), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_pc(d_out_pc), .out_opcode(d_out_opcode),
    .out_funct3(d_out_funct3), .out_funct7(d_out_funct7), .out_rs1(d_out_rs1),
    .out_rs2(d_out_rs2), .out_rd(d_out_rd), .out_imm(d_out_imm), .out_fmt(d_out_fmt),
    .out_illegal(d_out_illegal)
  );

  task automatic test_reset();
    #12;
    checks += 4;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    if ({out_pc, out_imm, out_rd, out_fmt} !== '0) begin
      failures++; $display("FAIL reset_data got pc=%h imm=%h rd=%0d fmt=%0d want 0",
                           out_pc, out_imm, out_rd, out_fmt);
    end
    if (d_out_valid !== 1'b0 || d_out_imm !== 64'h0) begin
      failures++; $display("FAIL reset_dut64 got valid=%b imm=%h want 0/0", d_out_valid, d_out_imm);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decode32();
    logic [31:0] t_inst [12];
    logic [31:0] t_imm  [12];
    logic [3:0]  t_fmt  [12];
    logic        t_ill  [12];
    logic [4:0]  t_rd   [12];
    logic [4:0]  t_rs1  [12];
    t_inst[0]  = 32'hFFF10093; t_imm[0]  = 32'hFFFFFFFF; t_fmt[0]  = FmtI;
    t_ill[0]   = 0; t_rd[0]  = 1;  t_rs1[0]  = 2;
    t_inst[1]  = 32'h40725193; t_imm[1]  = 32'h00000007; t_fmt[1]  = FmtI;
    t_ill[1]   = 0; t_rd[1]  = 3;  t_rs1[1]  = 4;
    t_inst[2]  = 32'hFE000EE3; t_imm[2]  = 32'hFFFFFFFC; t_fmt[2]  = FmtB;
    t_ill[2]   = 0; t_rd[2]  = 29; t_rs1[2]  = 0;
    t_inst[3]  = 32'h00000000; t_imm[3]  = 32'h0;        t_fmt[3]  = FmtBad;
    t_ill[3]   = 1; t_rd[3]  = 0;  t_rs1[3]  = 0;
    t_inst[4]  = 32'h020000B3; t_imm[4]  = 32'h0;        t_fmt[4]  = FmtBad;
    t_ill[4]   = 1; t_rd[4]  = 1;  t_rs1[4]  = 0;
    t_inst[5]  = 32'h00512423; t_imm[5]  = 32'h00000008; t_fmt[5]  = FmtS;
    t_ill[5]   = 0; t_rd[5]  = 8;  t_rs1[5]  = 2;
    t_inst[6]  = 32'h123452B7; t_imm[6]  = 32'h12345000; t_fmt[6]  = FmtLui;
    t_ill[6]   = 0; t_rd[6]  = 5;  t_rs1[6]  = 8;
    t_inst[7]  = 32'hF14020F3; t_imm[7]  = 32'h00000F14; t_fmt[7]  = FmtSys;
    t_ill[7]   = 0; t_rd[7]  = 1;  t_rs1[7]  = 0;
    t_inst[8]  = 32'h0FF0000F; t_imm[8]  = 32'h0;        t_fmt[8]  = FmtFence;
    t_ill[8]   = 0; t_rd[8]  = 0;  t_rs1[8]  = 0;
    t_inst[9]  = 32'h40111093; t_imm[9]  = 32'h0;        t_fmt[9]  = FmtBad;
    t_ill[9]   = 1; t_rd[9]  = 1;  t_rs1[9]  = 2;
    t_inst[10] = 32'hFF9FF06F; t_imm[10] = 32'hFFFFFFF8; t_fmt[10] = FmtJal;
    t_ill[10]  = 0; t_rd[10] = 0;  t_rs1[10] = 31;
    t_inst[11] = 32'h42115093; t_imm[11] = 32'h0;        t_fmt[11] = FmtBad;
    t_ill[11]  = 1; t_rd[11] = 1;  t_rs1[11] = 2;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_inst  = t_inst[i];
      in_pc    = 32'h1000 + 32'(i * 4);
      @(posedge clk); #1;
      checks += 6;
      if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(i * 4)) begin
        failures++; $display("FAIL dec32[%0d]_valid_pc got %b/%h want 1/%h", i, out_valid,
                             out_pc, 32'h1000 + 32'(i * 4));
      end
      if (out_imm !== t_imm[i]) begin
        failures++; $display("FAIL dec32[%0d]_imm got %h want %h", i, out_imm, t_imm[i]);
      end
      if (out_fmt !== t_fmt[i]) begin
        failures++; $display("FAIL dec32[%0d]_fmt got %0d want %0d", i, out_fmt, t_fmt[i]);
      end
      if (out_illegal !== t_ill[i]) begin
        failures++; $display("FAIL dec32[%0d]_illegal got %b want %b", i, out_illegal, t_ill[i]);
      end
      if (out_rd !== t_rd[i]) begin
        failures++; $display("FAIL dec32[%0d]_rd got %0d want %0d", i, out_rd, t_rd[i]);
      end
      if (out_rs1 !== t_rs1[i]) begin
        failures++; $display("FAIL dec32[%0d]_rs1 got %0d want %0d", i, out_rs1, t_rs1[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decode64();
    logic [31:0] t_inst [3];
    logic [63:0] t_imm  [3];
    logic [3:0]  t_fmt  [3];
    t_inst[0] = 32'h800000B7; t_imm[0] = 64'hFFFFFFFF80000000; t_fmt[0] = FmtLui;
    t_inst[1] = 32'h020000B3; t_imm[1] = 64'h0;                t_fmt[1] = FmtR;
    t_inst[2] = 32'h42115093; t_imm[2] = 64'h21;               t_fmt[2] = FmtI;
    d_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in_valid = 1'b1;
      d_in_inst  = t_inst[i];
      d_in_pc    = 64'h8000_0000_0000_0000 + 64'(i * 4);
      @(posedge clk); #1;
      checks += 3;
      if (d_out_valid !== 1'b1 || d_out_pc !== 64'h8000_0000_0000_0000 + 64'(i * 4)) begin
        failures++; $display("FAIL dec64[%0d]_valid_pc got %b/%h", i, d_out_valid, d_out_pc);
      end
      if (d_out_imm !== t_imm[i]) begin
        failures++; $display("FAIL dec64[%0d]_imm got %h want %h", i, d_out_imm, t_imm[i]);
      end
      if (d_out_fmt !== t_fmt[i] || d_out_illegal !== 1'b0) begin
        failures++; $display("FAIL dec64[%0d]_fmt_ill got %0d/%b want %0d/0", i, d_out_fmt,
                             d_out_illegal, t_fmt[i]);
      end
    end
    d_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall_stream();
    logic [31:0] pcs [4];
    int          sent = 0;
    int          recv = 0;
    logic        stall_seen = 1'b0;
    logic [31:0] stall_pc, stall_imm;
    logic        will_acc;
    for (int i = 0; i < 4; i++) pcs[i] = 32'h2000 + 32'(i * 16);
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 3);
      in_valid  = (sent < 4);
      in_inst   = 32'h00000013 | (32'(sent + 10) << 7) | (32'(sent) << 20);
      in_pc     = (sent < 4) ? pcs[sent] : 32'h0;
      will_acc  = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (out_pc !== pcs[recv] || out_rd !== 5'(recv + 10) || out_imm !== 32'(recv)) begin
          failures++; $display("FAIL stream_order[%0d] got pc=%h rd=%0d imm=%h want pc=%h rd=%0d",
                               recv, out_pc, out_rd, out_imm, pcs[recv], recv + 10);
        end
        recv++;
      end
      if (out_valid && !out_ready) begin
        if (stall_seen) begin
          checks++;
          if (out_pc !== stall_pc || out_imm !== stall_imm || out_pc !== pcs[0]) begin
            failures++; $display("FAIL stall_stable got pc=%h imm=%h want pc=%h imm=%h",
                                 out_pc, out_imm, stall_pc, stall_imm);
          end
        end else begin
          stall_seen = 1'b1;
          stall_pc   = out_pc;
          stall_imm  = out_imm;
        end
      end
      @(posedge clk); #1;
      if (will_acc) sent++;
      if (c == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++; $display("FAIL stall_in_ready_after1 got %b want 1", in_ready);
        end
      end
      if (c == 1) begin
        checks++;
        if (in_ready !== 1'b0 || sent !== 2) begin
          failures++; $display("FAIL stall_in_ready_after2 got %b sent=%0d want 0 sent=2",
                               in_ready, sent);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 4) begin
      failures++; $display("FAIL stream_count got %0d want 4", recv);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00100093; in_pc = 32'h3000;
    @(posedge clk); #1;
    in_inst   = 32'h00200113; in_pc = 32'h3004;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL flush_setup got in_ready=%b out_valid=%b want 0/1",
                           in_ready, out_valid);
    end
    flush   = 1'b1;
    in_inst = 32'h00300193; in_pc = 32'h3008;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_clear got out_valid=%b in_ready=%b want 0/1",
                           out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_ghost got out_valid=%b pc=%h want 0", out_valid, out_pc);
      end
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h00400213; in_pc = 32'h300C;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_drops_input got out_valid=%b want 0", out_valid);
    end
    in_inst = 32'h00500293; in_pc = 32'h3010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3010 || out_rd !== 5'd5) begin
      failures++; $display("FAIL flush_resume got %b/%h/%0d want 1/3010/5", out_valid, out_pc,
                           out_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00600313; in_pc = 32'h4000;
    @(posedge clk); #1;
    in_inst   = 32'h00700393; in_pc = 32'h4004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL areset_setup got %b/%b want 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
      failures++; $display("FAIL areset_immediate got valid=%b ready=%b pc=%h want 0/1/0",
                           out_valid, in_ready, out_pc);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h00800413; in_pc = 32'h4100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4100 || out_rd !== 5'd8) begin
      failures++; $display("FAIL areset_first_accept got %b/%h/%0d want 1/4100/8", out_valid,
                           out_pc, out_rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    d_flush = 1'b0; d_in_valid = 1'b0; d_in_inst = '0; d_in_pc = '0; d_out_ready = 1'b0;
    test_reset();
    test_decode32();
    test_decode64();
    test_stall_stream();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered, handshaked instruction-decode pipeline stage that is the parametrised successor to the single-cycle RV32I field/immediate decoder. It takes a fetched instruction and PC from the fetch stage over a valid/ready interface. It decodes register indices, function fields, format class, the XLEN-wide sign- or zero-extended immediate, and an illegal-instruction flag, then presents the result one cycle later to the execute stage through a two-entry skid buffer. It sits between instruction fetch and execute, and supports pipeline flush on branch redirect.

## Interface
- `XLEN`, 32: datapath width (32 or 64). Sets the immediate width, the PC width and the shamt width (5 bits for 32, 6 bits for 64).
- `MEXT`, 0: when 1, R-type with funct7 = 0000001 is legal (M extension).
- `clk` input 1: clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of all buffered entries.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept an instruction.
- `in_inst` input 32: raw instruction.
- `in_pc` input XLEN: PC of `in_inst`.
- `out_valid` output 1: a decoded entry is presented.
- `out_ready` input 1: execute accepts it.
- `out_pc` output XLEN: PC passed through.
- `out_opcode` output 7, `out_funct3` output 3, `out_funct7` output 7: raw fields.
- `out_rs1`, `out_rs2`, `out_rd` output 5 each: register indices.
- `out_imm` output XLEN: extended immediate.
- `out_fmt` output 4: format class (R, I, L, S, B, LUI, AUIPC, JAL, JALR, SYS, FENCE, BAD).
- `out_illegal` output 1: instruction is not decodable.

## Operation
- Combinational decode of `in_inst`. Fields are always extracted from the fixed bit positions regardless of format.
- Immediates are sign-extended from inst[31] to XLEN unless stated otherwise:
  - I, L, JALR: inst[31:20].
  - Shift-immediate, opcode I with funct3 001 or 101: zero-extended shamt, inst[24:20] for XLEN=32 and inst[25:20] for XLEN=64.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[7], inst[30:25], inst[11:8], 0}.
  - LUI and AUIPC: {inst[31:12], 12'b0}, sign-extended above bit 31.
  - JAL: {inst[19:12], inst[20], inst[30:21], 0}.
  - SYS (1110011): zero-extended inst[31:20], the CSR address.
  - R, FENCE (0001111) and illegal instructions: 0.
- `out_illegal` = 1 in any of these cases:
  - inst[1:0] != 11.
  - Unknown opcode.
  - R-type with funct7 not 0000000 or 0100000, except 0000001 when MEXT = 1.
  - Shift-immediate with an illegal funct7 or shamt bits (for XLEN=32, funct7 must be 0000000, or 0100000 for srai).
  - In these cases `out_fmt` = BAD and `out_imm` = 0.
- Skid buffer: main register M and skid register K, each with its own valid bit.
  - `in_ready` = !K.valid, driven from a register.
  - `out_*` always reflects M.
  - Input accepted while M is full and stalled (`out_valid` && !`out_ready`): the entry goes to K.
  - M drains while K is full: K moves to M, and K.valid clears.
  - Accept and drain in the same cycle with K empty: the new entry goes to M, giving full throughput.
- `flush` = 1: next edge clears M.valid and K.valid, and any input in that cycle is dropped. Flush has priority over every other event.

## Timing
- Reset values: `out_valid` 0, `in_ready` 1, all data outputs 0, K empty.
- Latency: an instruction accepted on edge N is visible on `out_*` after edge N.
- Throughput: 1 per cycle while `out_ready` = 1.
- Stall tolerance: one extra entry is absorbed after `out_ready` falls. `in_ready` falls the cycle after K fills.
- Data outputs hold stable while `out_valid` && !`out_ready`.
- Reset asserted mid-stream discards all entries immediately (asynchronous). First acceptance is on the first edge after `rst_n` rises.

## Structure
- Shared package: opcode constants (including SYS and FENCE), the `out_fmt` enumeration, and the decoded-entry bundle width.
- Sub-module `inst_imm_gen` (combinational: inst and XLEN in; imm, fmt and illegal out), instantiated once.

## Test plan
- XLEN=32, 0xFFF10093 (addi x1,x2,-1) with `out_ready`=1 → next cycle `out_valid`=1, rd=1, rs1=2, imm=0xFFFFFFFF, fmt I, illegal 0.
- 0x40725193 (srai x3,x4,7) → imm=7. 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, fmt B.
- XLEN=64, 0x800000B7 (lui x1,0x80000) → imm=0xFFFFFFFF80000000.
- 0x00000000 and 0x0200_00B3 with MEXT=0 → illegal 1, fmt BAD, imm 0. Same 0x020000B3 with MEXT=1 → legal R.
- Stream of 4 instructions with `out_ready` low for 3 cycles → `in_ready` drops after 2 accepted, no loss or reorder, outputs stable during stall.
- `flush` while M and K are full and `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1, flushed entries never appear. `rst_n` low mid-stall → `out_valid`=0 immediately.
